// File: rtl/vmicro16_uart_rx_apb_pkg.sv
// Shared constants for the vmicro16 UART receiver: register offsets, STATUS bit
// positions, receiver FSM encoding and the interconnect slot of this peripheral.
package vmicro16_uart_rx_apb_pkg;

  localparam logic [1:0] UART_RX_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_RX_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_RX_REG_DIV    = 2'd2;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_PARITY_ERR = 4;
  // With parity framing bit4 carries parity_err, so the count field moves up one.
`ifdef VMICRO16_UART_RX_PARITY_EN
  localparam int ST_COUNT_LSB  = 5;
`else
  localparam int ST_COUNT_LSB  = 4;
`endif

  localparam int          DIV_W   = 16;
  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam int         APB_SLAVE_IDX_UART1 = 3;
  localparam logic [7:0] APB_PSELX_UART1     = 8'(1 << APB_SLAVE_IDX_UART1);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/vmicro16_uart_rx_apb_fifo.sv
// vmicro16_fifo: synchronous FIFO shared by the UART RX and TX paths.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module vmicro16_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vmicro16_uart_rx_apb.sv
// APB slave UART receiver: 8N1 deserialiser feeding a receive FIFO, with STATUS,
// baud divisor and a level irq. Define VMICRO16_UART_RX_PARITY_EN for 8E1 framing.
module vmicro16_uart_rx_apb
  import vmicro16_uart_rx_apb_pkg::*;
#(
  parameter int BUS_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 rx_wire,
  output logic                 irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             access, rd_pop, wr_status, wr_div;
  logic [1:0]       reg_sel;
  logic             unused_bits;

  logic             rx_meta_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_act_q, div_act_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             rx_push, set_frame, set_overrun;
  logic             half_tick, full_tick;

  logic             overrun_q, frame_err_q;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic [31:0]      count_wide;
  logic [3:0]       count_sat;
  logic [15:0]      status_w;
  logic [BUS_WIDTH-1:0] rdata;

`ifdef VMICRO16_UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d, set_parity, parity_err_q;
`endif

  // Register access is suppressed while reset is held so the bus outputs read 0.
  assign access    = S_PSELx & S_PENABLE & reset;
  assign reg_sel   = S_PADDR[1:0];
  assign rd_pop    = access & ~S_PWRITE & (reg_sel == UART_RX_REG_DATA);
  assign wr_status = access &  S_PWRITE & (reg_sel == UART_RX_REG_STATUS);
  assign wr_div    = access &  S_PWRITE & (reg_sel == UART_RX_REG_DIV);
  assign unused_bits = ^{S_PADDR, S_PWDATA};

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_wire;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign half_tick = (cnt_q == (div_act_q >> 1) - 16'd1);
  assign full_tick = (cnt_q == div_act_q - 16'd1);

  // NOTE: every output of this block is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    armed_d   = 1'b0;
    div_act_d = div_act_q;
    rx_push   = 1'b0;
    set_frame = 1'b0;
`ifdef VMICRO16_UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    set_parity = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        cnt_d   = '0;
        // A start edge only counts after the line has been seen idle-high.
        armed_d = armed_q | rx_s_q;
        if (armed_q && !rx_s_q) begin
          state_d   = RX_START;
          div_act_d = div_q;
        end
      end
      RX_START: begin
        if (half_tick) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (full_tick) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef VMICRO16_UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef VMICRO16_UART_RX_PARITY_EN
      RX_PARITY: begin
        if (full_tick) begin
          cnt_d      = '0;
          par_bad_d  = ^{shift_q, rx_s_q};
          set_parity = par_bad_d;
          state_d    = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (full_tick) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (!rx_s_q) begin
            set_frame = 1'b1;
          end else begin
`ifdef VMICRO16_UART_RX_PARITY_EN
            rx_push = ~par_bad_q;
`else
            rx_push = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      div_act_q <= 16'(CLKS_PER_BIT);
`ifdef VMICRO16_UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      div_act_q <= div_act_d;
`ifdef VMICRO16_UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  vmicro16_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .din_i   (shift_q),
    .pop_i   (rd_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A full FIFO still takes the byte when a DATA read frees a slot this cycle.
  assign set_overrun = rx_push & fifo_full & ~rd_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      div_q       <= 16'(CLKS_PER_BIT);
`ifdef VMICRO16_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      overrun_q   <= set_overrun | (overrun_q & ~(wr_status & S_PWDATA[ST_OVERRUN]));
      frame_err_q <= set_frame | (frame_err_q & ~(wr_status & S_PWDATA[ST_FRAME_ERR]));
`ifdef VMICRO16_UART_RX_PARITY_EN
      parity_err_q <= set_parity | (parity_err_q & ~(wr_status & S_PWDATA[ST_PARITY_ERR]));
`endif
      if (wr_div) div_q <= clamp_div(S_PWDATA[DIV_W-1:0]);
    end
  end

  assign count_wide = 32'(fifo_count);
  assign count_sat  = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];

  always_comb begin
    status_w                             = '0;
    status_w[ST_NOT_EMPTY]               = ~fifo_empty;
    status_w[ST_FULL]                    = fifo_full;
    status_w[ST_OVERRUN]                 = overrun_q;
    status_w[ST_FRAME_ERR]               = frame_err_q;
    status_w[ST_COUNT_LSB +: 4]          = count_sat;
`ifdef VMICRO16_UART_RX_PARITY_EN
    status_w[ST_PARITY_ERR]              = parity_err_q;
`endif
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      UART_RX_REG_DATA:   rdata = fifo_empty ? '0 : BUS_WIDTH'(fifo_dout);
      UART_RX_REG_STATUS: rdata = BUS_WIDTH'(status_w);
      UART_RX_REG_DIV:    rdata = BUS_WIDTH'(div_q);
      default:            rdata = '0;
    endcase
  end

  assign S_PRDATA = (access & ~S_PWRITE) ? rdata : '0;
  assign S_PREADY = access;
  assign irq      = ~fifo_empty;

endmodule

// File: tb/tb_vmicro16_uart_rx_apb.sv
// Scoreboard bench for vmicro16_uart_rx_apb: reads queue an expected {data, irq}
// and a monitor checks each APB read access cycle against the queue head.
module tb_vmicro16_uart_rx_apb;

  localparam int DIV_TB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] paddr, pwdata;
  logic        pwrite, psel, penable;
  logic [15:0] prdata;
  logic        pready, irq;
  logic        rx_wire;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  vmicro16_uart_rx_apb dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (paddr),
    .S_PWRITE  (pwrite),
    .S_PSELx   (psel),
    .S_PENABLE (penable),
    .S_PWDATA  (pwdata),
    .S_PRDATA  (prdata),
    .S_PREADY  (pready),
    .rx_wire   (rx_wire),
    .irq       (irq)
  );

  // Monitor: every read access cycle consumes one expectation.
  always @(negedge clk) begin
    if (pready && !pwrite) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_read: got data=%h irq=%b, nothing expected", prdata, irq);
      end else begin
        cur = sb_q.pop_front();
        if (prdata !== cur.data || irq !== cur.irq) begin
          n_miss++;
          $display("FAIL %s: got data=%h irq=%b, expected data=%h irq=%b",
                   cur.name, prdata, irq, cur.data, cur.irq);
        end
      end
    end
  end

  task automatic apb_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; paddr = {14'd0, a}; pwdata = d; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, input logic [15:0] d,
                          input logic i, input string name);
    exp_t e;
    e.name = name; e.data = d; e.irq = i;
    sb_q.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b0; paddr = {14'd0, a}; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic drive_bit(input logic v);
    @(posedge clk); #1;
    rx_wire = v;
    repeat (DIV_TB - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(stop_bit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, queue=%0d", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; rx_wire = 1'b1;
    repeat (4) @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state
    apb_read(2'd1, 16'h0000, 1'b0, "reset_status");
    apb_read(2'd2, 16'd868,  1'b0, "reset_div");
    apb_read(2'd0, 16'h0000, 1'b0, "reset_data_empty");

    // Divisor clamp, unmapped register, then DIV=4
    apb_write(2'd2, 16'd2);
    apb_read(2'd2, 16'd4, 1'b0, "div_clamp");
    apb_write(2'd3, 16'hFFFF);
    apb_read(2'd3, 16'h0000, 1'b0, "reg3_zero");
    apb_write(2'd2, 16'd4);
    apb_read(2'd2, 16'd4, 1'b0, "div_4");

    // Single byte
    send_frame(8'hA5, 1'b1);
    repeat (4) @(posedge clk);
    apb_read(2'd1, 16'h0011, 1'b1, "a5_status");
    apb_read(2'd0, 16'h00A5, 1'b1, "a5_data");
    apb_read(2'd1, 16'h0000, 1'b0, "a5_status_after");

    // Nine bytes into an eight-deep FIFO
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b1);
    repeat (4) @(posedge clk);
    apb_read(2'd1, 16'h0087, 1'b1, "ovr_status");
    for (int k = 1; k <= 8; k++) apb_read(2'd0, 16'(k), 1'b1, $sformatf("ovr_data_%0d", k));
    apb_read(2'd1, 16'h0004, 1'b0, "ovr_sticky");
    apb_write(2'd1, 16'h0004);
    apb_read(2'd1, 16'h0000, 1'b0, "ovr_cleared");

    // Framing error then a good frame
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b1);
    repeat (4) @(posedge clk);
    apb_read(2'd1, 16'h0008, 1'b0, "frame_err_status");
    send_frame(8'h7E, 1'b1);
    repeat (4) @(posedge clk);
    apb_read(2'd1, 16'h0019, 1'b1, "after_ferr_status");
    apb_read(2'd0, 16'h007E, 1'b1, "after_ferr_data");
    apb_write(2'd1, 16'h0008);
    apb_read(2'd1, 16'h0000, 1'b0, "ferr_cleared");

    // One-cycle glitch
    @(posedge clk); #1 rx_wire = 1'b0;
    @(posedge clk); #1 rx_wire = 1'b1;
    repeat (20) @(posedge clk);
    apb_read(2'd1, 16'h0000, 1'b0, "glitch_status");
    apb_read(2'd0, 16'h0000, 1'b0, "glitch_data");

    // Reset during bit 4 with one byte already queued
    send_frame(8'h11, 1'b1);
    repeat (4) @(posedge clk);
    apb_read(2'd1, 16'h0011, 1'b1, "pre_reset_status");
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(k[0]);
    @(posedge clk); #1 rx_wire = 1'b1;
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk); #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    apb_read(2'd1, 16'h0000, 1'b0, "post_reset_status");
    apb_read(2'd2, 16'd868,  1'b0, "post_reset_div");
    apb_write(2'd2, 16'd4);
    send_frame(8'h55, 1'b1);
    repeat (4) @(posedge clk);
    apb_read(2'd0, 16'h0055, 1'b1, "post_reset_data");

    // Full FIFO: DATA read lands in the stop-bit push cycle
    for (int k = 0; k < 8; k++) send_frame(8'h21 + 8'(k), 1'b1);
    repeat (4) @(posedge clk);
    apb_read(2'd1, 16'h0083, 1'b1, "full_status");
    fork
      send_frame(8'h29, 1'b1);
      begin
        repeat (39) @(posedge clk);
        apb_read(2'd0, 16'h0021, 1'b1, "coincide_pop");
      end
    join
    repeat (4) @(posedge clk);
    apb_read(2'd1, 16'h0083, 1'b1, "coincide_status");
    for (int k = 1; k <= 8; k++)
      apb_read(2'd0, 16'h0021 + 16'(k), 1'b1, $sformatf("coincide_data_%0d", k));
    apb_read(2'd1, 16'h0000, 1'b0, "final_status");

    repeat (4) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
